// File: rtl/updown_count_sequencer_if.sv
// Command handshake and counter datapath bus for the up/down count sequencer.
// The master side issues commands and hosts the counter; the slave side is the sequencer.
interface updown_count_sequencer_if #(
    parameter int LOOP_W = 4
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_start;
    logic [3:0]        cmd_end;
    logic              cmd_dir;
    logic [LOOP_W-1:0] cmd_loops;

    // Counter datapath
    logic [3:0]        cnt_value;
    logic              cnt_load;
    logic [3:0]        cnt_load_val;
    logic              cnt_en;
    logic              cnt_sel;

    modport master (
        output cmd_valid, cmd_start, cmd_end, cmd_dir, cmd_loops,
        input  cmd_ready,
        output cnt_value,
        input  cnt_load, cnt_load_val, cnt_en, cnt_sel
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_end, cmd_dir, cmd_loops,
        output cmd_ready,
        input  cnt_value,
        output cnt_load, cnt_load_val, cnt_en, cnt_sel
    );
endinterface

// File: rtl/updown_count_sequencer.sv
// Sequencer for a 4-bit up/down counter: loads a start value, steps the counter
// until it reaches the end value, repeats for the requested number of passes,
// then pulses done.
module updown_count_sequencer #(
    parameter int LOOP_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_count_sequencer_if.slave bus,
    input  logic                 pause,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [LOOP_W-1:0]    loops_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state, state_next;
    logic [3:0]        start_val, start_val_next;
    logic [3:0]        end_val, end_val_next;
    logic              dir, dir_next;
    logic [LOOP_W-1:0] loops_left, loops_left_next;
    logic [LOOP_W-1:0] loops_done_r, loops_done_next;
    logic              at_end;

    assign at_end = (bus.cnt_value == end_val);

    // Output decodes; abort suppresses every counter strobe and the done pulse.
    always_comb begin
        bus.cmd_ready    = (state == IDLE);
        busy             = (state != IDLE);
        bus.cnt_load     = (state == LOAD) && !abort;
        bus.cnt_en       = (state == RUN) && !abort && !pause && !at_end;
        done             = (state == DONE) && !abort;
        bus.cnt_load_val = start_val;
        bus.cnt_sel      = dir;
        loops_done       = loops_done_r;
    end

    // Next-state logic for the sequencing FSM and its command registers.
    always_comb begin
        state_next      = state;
        start_val_next  = start_val;
        end_val_next    = end_val;
        dir_next        = dir;
        loops_left_next = loops_left;
        loops_done_next = loops_done_r;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    start_val_next  = bus.cmd_start;
                    end_val_next    = bus.cmd_end;
                    dir_next        = bus.cmd_dir;
                    // A zero repeat count still runs one pass
                    loops_left_next = (bus.cmd_loops == '0) ? LOOP_W'(1) : bus.cmd_loops;
                    loops_done_next = '0;
                    state_next      = LOAD;
                end
            end
            LOAD: begin
                state_next = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!pause && at_end) begin
                    if (loops_done_r != '1) begin
                        loops_done_next = loops_done_r + LOOP_W'(1);
                    end
                    if (loops_left > LOOP_W'(1)) begin
                        loops_left_next = loops_left - LOOP_W'(1);
                        state_next      = LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            start_val    <= '0;
            end_val      <= '0;
            dir          <= 1'b0;
            loops_left   <= '0;
            loops_done_r <= '0;
        end else begin
            state        <= state_next;
            start_val    <= start_val_next;
            end_val      <= end_val_next;
            dir          <= dir_next;
            loops_left   <= loops_left_next;
            loops_done_r <= loops_done_next;
        end
    end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed bench for updown_count_sequencer with a behavioural 4-bit counter.
module tb_updown_count_sequencer;

    localparam int LOOP_W = 4;

    logic              clk;
    logic              reset;
    logic              pause;
    logic              abort;
    logic              busy;
    logic              done;
    logic [LOOP_W-1:0] loops_done;

    updown_count_sequencer_if #(.LOOP_W(LOOP_W)) bus ();

    updown_count_sequencer #(.LOOP_W(LOOP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pause      (pause),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .loops_done (loops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter datapath the sequencer drives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cnt_value <= 4'h0;
        end else if (bus.cnt_load) begin
            bus.cnt_value <= bus.cnt_load_val;
        end else if (bus.cnt_en) begin
            bus.cnt_value <= bus.cnt_sel ? bus.cnt_value + 4'h1 : bus.cnt_value - 4'h1;
        end
    end

    int errors = 0;
    int checks = 0;

    // Per-command observation state, only touched by the main initial block
    int cyc;
    int en_n, load_n, done_n, done_cyc, first_en, last_en, sel_bad, ready_busy;
    logic exp_dir;
    logic [LOOP_W-1:0] ld_trace [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs(input logic d);
        cyc = 0; en_n = 0; load_n = 0; done_n = 0; done_cyc = -1;
        first_en = -1; last_en = -1; sel_bad = 0; ready_busy = 0; exp_dir = d;
        for (int i = 0; i < 8; i++) ld_trace[i] = '0;
    endtask

    // Record the settled values of the current cycle, then advance past one edge.
    task automatic tick();
        if (bus.cnt_en) begin
            en_n++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (bus.cnt_sel !== exp_dir) sel_bad++;
        end
        if (bus.cnt_load) begin
            if (load_n < 8) ld_trace[load_n] = loops_done;
            load_n++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy && bus.cmd_ready) ready_busy++;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic accept(input logic [3:0] s, input logic [3:0] e, input logic d,
                          input logic [LOOP_W-1:0] l);
        bus.cmd_start = s; bus.cmd_end = e; bus.cmd_dir = d; bus.cmd_loops = l;
        bus.cmd_valid = 1'b1;
        clear_obs(d);
        #1;
        tick();
        bus.cmd_valid = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        while (!bus.cmd_ready && cyc < budget) tick();
        check({tag, "_timeout"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_load"}, 32'(bus.cnt_load), 32'd0);
        check({tag, "_en"}, 32'(bus.cnt_en), 32'd0);
        check({tag, "_ldval"}, 32'(bus.cnt_load_val), 32'd0);
        check({tag, "_sel"}, 32'(bus.cnt_sel), 32'd0);
        check({tag, "_loops"}, 32'(loops_done), 32'd0);
    endtask

    initial begin
        reset = 1'b0; pause = 1'b0; abort = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_start = '0; bus.cmd_end = '0;
        bus.cmd_dir = 1'b0; bus.cmd_loops = '0;
        clear_obs(1'b0);
        #12;
        check_reset_outputs("rst");
        reset = 1'b1;
        @(posedge clk);
        #2;

        // 1: up 3 -> 7, one pass
        accept(4'h3, 4'h7, 1'b1, 4'd1);
        check("t1_load_c1", 32'(bus.cnt_load), 32'd1);
        check("t1_ldval", 32'(bus.cnt_load_val), 32'h3);
        check("t1_en_c1", 32'(bus.cnt_en), 32'd0);
        check("t1_ready_c1", 32'(bus.cmd_ready), 32'd0);
        check("t1_busy_c1", 32'(busy), 32'd1);
        wait_idle("t1", 40);
        check("t1_en_n", 32'(en_n), 32'd4);
        check("t1_first_en", 32'(first_en), 32'd2);
        check("t1_last_en", 32'(last_en), 32'd5);
        check("t1_sel", 32'(sel_bad), 32'd0);
        check("t1_load_n", 32'(load_n), 32'd1);
        check("t1_done_n", 32'(done_n), 32'd1);
        check("t1_done_cyc", 32'(done_cyc), 32'd7);
        check("t1_ready_cyc", 32'(cyc), 32'd8);
        check("t1_loops", 32'(loops_done), 32'd1);
        check("t1_value", 32'(bus.cnt_value), 32'h7);

        // 2: down 2 -> E wrapping through 0
        accept(4'h2, 4'hE, 1'b0, 4'd1);
        wait_idle("t2", 40);
        check("t2_en_n", 32'(en_n), 32'd4);
        check("t2_sel", 32'(sel_bad), 32'd0);
        check("t2_done_n", 32'(done_n), 32'd1);
        check("t2_done_cyc", 32'(done_cyc), 32'd7);
        check("t2_value", 32'(bus.cnt_value), 32'hE);

        // 3: up 0 -> 2, three passes
        accept(4'h0, 4'h2, 1'b1, 4'd3);
        wait_idle("t3", 60);
        check("t3_load_n", 32'(load_n), 32'd3);
        check("t3_en_n", 32'(en_n), 32'd6);
        check("t3_done_n", 32'(done_n), 32'd1);
        check("t3_done_cyc", 32'(done_cyc), 32'd13);
        check("t3_ld_loops1", 32'(ld_trace[1]), 32'd1);
        check("t3_ld_loops2", 32'(ld_trace[2]), 32'd2);
        check("t3_loops", 32'(loops_done), 32'd3);

        // 4: scenario 1 with pause held three cycles at value 5
        accept(4'h3, 4'h7, 1'b1, 4'd1);
        while (cyc < 4) tick();
        check("t4_value_c4", 32'(bus.cnt_value), 32'h5);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_paused_en", 32'(bus.cnt_en), 32'd0);
            tick();
        end
        pause = 1'b0;
        #1;
        check("t4_value_c7", 32'(bus.cnt_value), 32'h5);
        wait_idle("t4", 40);
        check("t4_en_n", 32'(en_n), 32'd4);
        check("t4_done_cyc", 32'(done_cyc), 32'd10);
        check("t4_ready_cyc", 32'(cyc), 32'd11);

        // 5a: abort at value 5
        accept(4'h3, 4'h7, 1'b1, 4'd1);
        while (cyc < 4) tick();
        abort = 1'b1;
        #1;
        check("t5_abort_en", 32'(bus.cnt_en), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        tick();
        abort = 1'b0;
        #1;
        check("t5_ready", 32'(bus.cmd_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_done", 32'(done_n), 32'd0);
        check("t5_loops_kept", 32'(loops_done), 32'd0);

        // 5b: asynchronous reset mid second pass
        accept(4'h8, 4'h9, 1'b1, 4'd3);
        while (cyc < 5) tick();
        check("t5b_en_c5", 32'(bus.cnt_en), 32'd1);
        check("t5b_loops_c5", 32'(loops_done), 32'd1);
        check("t5b_ldval", 32'(bus.cnt_load_val), 32'h8);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("t5b_async");
        #1;
        reset = 1'b1;
        @(posedge clk);
        #2;

        // 6: start == end, zero loops, with cmd_valid held during the run
        accept(4'h9, 4'h9, 1'b0, 4'd0);
        check("t6_load_c1", 32'(bus.cnt_load), 32'd1);
        bus.cmd_start = 4'h1; bus.cmd_end = 4'h4; bus.cmd_dir = 1'b1; bus.cmd_loops = 4'd5;
        bus.cmd_valid = 1'b1;
        #1;
        wait_idle("t6", 40);
        bus.cmd_valid = 1'b0;
        check("t6_en_n", 32'(en_n), 32'd0);
        check("t6_load_n", 32'(load_n), 32'd1);
        check("t6_done_cyc", 32'(done_cyc), 32'd3);
        check("t6_ready_cyc", 32'(cyc), 32'd4);
        check("t6_ready_busy", 32'(ready_busy), 32'd0);
        check("t6_loops", 32'(loops_done), 32'd1);
        check("t6_ldval", 32'(bus.cnt_load_val), 32'h9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updown_count_sequencer.md
Name: updown_count_sequencer

Overview:
Controller that sequences a 4-bit hexadecimal up/down counter datapath with load and enable. It accepts one command at a time through a valid/ready handshake. Each command sets a start value, an end value, a direction and a repeat count. The block loads the counter, enables it step by step until it reaches the end value, repeats the pass as commanded, then reports completion. It sits between the control logic and the counter instance, which provides load, enable, up/down select and a registered 4-bit value.

Parameters:
LOOP_W, 4, width of the repeat-count field and of the completed-pass counter

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_start  input  4  value loaded into the counter at the start of each pass
cmd_end  input  4  terminal value of each pass
cmd_dir  input  1  1 = count up (+1 mod 16), 0 = count down (-1 mod 16)
cmd_loops  input  LOOP_W  number of passes; 0 is treated as 1
pause  input  1  freezes the sequence while high (RUN state only)
abort  input  1  terminates the active command
cnt_value  input  4  current counter value; updates the cycle after a load or enable
cnt_load  output  1  counter loads cnt_load_val on the next edge
cnt_load_val  output  4  load value (registered copy of cmd_start)
cnt_en  output  1  counter steps by one on the next edge
cnt_sel  output  1  direction to the counter (registered copy of cmd_dir)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when all passes complete normally
loops_done  output  LOOP_W  passes completed for the current or last command

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cmd_ready=1, busy=0, done=0, cnt_load=0, cnt_en=0, cnt_load_val=0, cnt_sel=0, loops_done=0, internal loops_left=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready=1. A command is accepted when cmd_valid=1 on a clock edge.
  - On acceptance, register start, end, dir and loops_left (max(cmd_loops,1)).
  - On acceptance, clear loops_done and go to LOAD.
  - abort and pause are ignored in IDLE.
- LOAD: cnt_load=1 and cnt_en=0. Always goes to RUN on the next edge.
- RUN, with cnt_value != end and pause=0: cnt_en=1. State holds.
- RUN, with cnt_value == end and pause=0: cnt_en=0 and loops_done increments.
  - If loops_left > 1: loops_left decrements and the next state is LOAD.
  - Otherwise: the next state is DONE.
- RUN, with pause=1: cnt_en=0, no transition, no terminal detection.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in LOAD, RUN or DONE: next state is IDLE.
  - cnt_en and cnt_load are forced to 0 in that same cycle.
  - done is not pulsed; loops_done keeps its value.
  - abort has priority over pause and over terminal detection.
- cnt_en and cnt_load are combinational decodes of state, pause, abort and cnt_value. They are never high together.
- Steps per pass: (end-start) mod 16 when counting up, (start-end) mod 16 when counting down. Counting wraps modulo 16. start==end gives zero enable pulses.
- cmd_valid while busy is ignored, and command inputs are not sampled.
- Latency, from an acceptance edge at cycle 0 with loops=1 and N steps:
  - LOAD at cycle 1.
  - cnt_en high during cycles 2..N+1.
  - Terminal detected at cycle N+2.
  - done at cycle N+3.
  - cmd_ready at cycle N+4.
- loops_done saturates at its maximum value (no wrap).

Test Plan:
1. Accept start=3, end=7, dir=1, loops=1 at cycle 0 -> cnt_load=1 with load_val=3 at cycle 1; cnt_en high cycles 2-5 (4 pulses, cnt_sel=1); done pulse at cycle 7; cmd_ready=1 at cycle 8; loops_done=1.
2. Down with wrap: start=2, end=E, dir=0, loops=1 -> values 2,1,0,F,E; exactly 4 cnt_en pulses with cnt_sel=0; single done pulse.
3. Repeat: start=0, end=2, dir=1, loops=3 -> 3 cnt_load pulses, 6 cnt_en pulses, loops_done steps 1,2,3, exactly one done.
4. Pause held high 3 cycles while cnt_value=5 in scenario 1 -> cnt_en low for those cycles, total of 4 pulses unchanged, done delayed by 3 cycles.
5. Abort at cnt_value=5 in RUN -> cnt_en=0 that cycle, IDLE and cmd_ready=1 next cycle, no done. Then drive reset=0 mid-run in a new command -> all outputs reach reset values immediately, without waiting for clk.
6. start=end=9, loops=0 -> treated as 1 pass: load at cycle 1, zero cnt_en pulses, done at cycle 3. cmd_valid asserted during that run is ignored and cmd_ready stays 0.
